// File: rtl/div32_seq.sv
// Sequential radix-2 restoring divider, signed or unsigned, one bit per cycle.
// Divide-by-zero and signed MIN/-1 skip the iteration and finish in one cycle.
module div32_seq #(
  parameter int DATA_N = 32
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iREQ_VALID,
  input  logic              iREQ_SIGNED,
  input  logic [DATA_N-1:0] iSOURCE0,
  input  logic [DATA_N-1:0] iSOURCE1,
  output logic              oREQ_BUSY,
  output logic              oOUT_VALID,
  output logic [DATA_N-1:0] oQUOTIENT,
  output logic [DATA_N-1:0] oREMAINDER,
  output logic              oDIV0,
  output logic              oOF,
  output logic              oSF,
  output logic              oZF
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = (DATA_N > 1) ? $clog2(DATA_N) : 1;
  localparam logic [DATA_N-1:0] MIN_VAL = {1'b1, {(DATA_N-1){1'b0}}};

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [DATA_N-1:0] r_rem, r_quo, r_div;
  logic              r_q_neg, r_r_neg;
  logic [DATA_N-1:0] r_quotient, r_remainder;
  logic              r_div0, r_of, r_sf, r_zf;

  logic              w_accept, w_div0, w_ovf, w_neg0, w_neg1, w_fit, w_last;
  logic [DATA_N-1:0] w_mag0, w_mag1, w_rem_next, w_quo_next, w_q_final, w_r_final;
  logic [DATA_N:0]   w_rem_sh;
  logic [DATA_N+1:0] w_trial;

  assign w_accept = iREQ_VALID & (r_state == IDLE);
  assign w_div0   = (iSOURCE1 == '0);
  assign w_ovf    = iREQ_SIGNED & (iSOURCE0 == MIN_VAL) & (iSOURCE1 == '1);
  assign w_neg0   = iREQ_SIGNED & iSOURCE0[DATA_N-1];
  assign w_neg1   = iREQ_SIGNED & iSOURCE1[DATA_N-1];
  assign w_mag0   = w_neg0 ? -iSOURCE0 : iSOURCE0;
  assign w_mag1   = w_neg1 ? -iSOURCE1 : iSOURCE1;

  // Extra top bit on the trial keeps the borrow visible for full-range divisors.
  assign w_rem_sh   = {r_rem, r_quo[DATA_N-1]};
  assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_div};
  assign w_fit      = ~w_trial[DATA_N+1];
  assign w_rem_next = w_fit ? w_trial[DATA_N-1:0] : w_rem_sh[DATA_N-1:0];
  assign w_quo_next = {r_quo[DATA_N-2:0], w_fit};
  assign w_q_final  = r_q_neg ? -w_quo_next : w_quo_next;
  assign w_r_final  = r_r_neg ? -w_rem_next : w_rem_next;
  assign w_last     = (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = (w_div0 | w_ovf) ? DONE : CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) r_state <= IDLE;
    else             r_state <= w_state_next;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div0      <= 1'b0;
      r_of        <= 1'b0;
      r_sf        <= 1'b0;
      r_zf        <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CW'(DATA_N - 1);
      r_rem   <= '0;
      r_quo   <= w_mag0;
      r_div   <= w_mag1;
      r_q_neg <= w_neg0 ^ w_neg1;
      r_r_neg <= w_neg0;
      if (w_div0) begin
        r_quotient  <= '1;
        r_remainder <= iSOURCE0;
        r_div0      <= 1'b1;
        r_of        <= 1'b0;
        r_sf        <= 1'b1;
        r_zf        <= 1'b0;
      end else if (w_ovf) begin
        r_quotient  <= MIN_VAL;
        r_remainder <= '0;
        r_div0      <= 1'b0;
        r_of        <= 1'b1;
        r_sf        <= 1'b1;
        r_zf        <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quotient  <= w_q_final;
        r_remainder <= w_r_final;
        r_div0      <= 1'b0;
        r_of        <= 1'b0;
        r_sf        <= w_q_final[DATA_N-1];
        r_zf        <= (w_q_final == '0);
      end
    end
  end

  assign oREQ_BUSY  = (r_state != IDLE);
  assign oOUT_VALID = (r_state == DONE);
  assign oQUOTIENT  = r_quotient;
  assign oREMAINDER = r_remainder;
  assign oDIV0      = r_div0;
  assign oOF        = r_of;
  assign oSF        = r_sf;
  assign oZF        = r_zf;

endmodule
